// File: rtl/bmu_issue_arbiter.sv
// Round-robin issue controller sharing one BMU between NREQ requesters, with
// an in-order tag pipe that routes each result back to its issuer and a flush/quiesce handshake.
module bmu_issue_arbiter #(
  parameter int NREQ = 2,
  parameter int AP_W = 23,
  parameter int LAT  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*32-1:0]     req_a,
  input  logic [NREQ*32-1:0]     req_b,
  input  logic [NREQ*AP_W-1:0]   req_ap,
  input  logic [NREQ-1:0]        req_csr_ren,
  input  logic [NREQ*32-1:0]     req_csr_rddata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [31:0]            rsp_result,
  output logic                   rsp_error,
  input  logic                   flush,
  output logic                   flush_done,
  input  logic                   scan_mode,
  output logic                   bmu_rst_l,
  output logic                   bmu_valid_in,
  output logic                   bmu_csr_ren_in,
  output logic [31:0]            bmu_a_in,
  output logic [31:0]            bmu_b_in,
  output logic [31:0]            bmu_csr_rddata_in,
  output logic [AP_W-1:0]        bmu_ap,
  output logic                   bmu_scan_mode,
  input  logic [31:0]            bmu_result_ff,
  input  logic                   bmu_error
);

  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(LAT + 3);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              run_en;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic              accept;
  logic [31:0]       sel_a, sel_b, sel_csr;
  logic [AP_W-1:0]   sel_ap;
  logic              sel_csr_ren;
  logic [LAT:0]      tag_vld;
  logic [ID_W-1:0]   tag_id [LAT+1];
  logic              tag_out;
  logic [CNT_W-1:0]  inflight;

  assign bmu_rst_l     = ~rst;
  assign bmu_scan_mode = scan_mode;
  assign tag_out       = tag_vld[LAT];

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0) state_nxt = flush ? HALTED : RUN;
      HALTED:  if (!flush) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    run_en     = (state == RUN);
    flush_done = (state == HALTED);
  end

  // Second pass overrides the first only when a valid requester sits at or above rr_ptr.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        winner = ID_W'(i);
        found  = 1'b1;
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
        winner = ID_W'(i);
        found  = 1'b1;
      end
    end
  end

  assign accept = found && run_en && !flush && !rst;

  always_comb begin
    req_ready   = '0;
    sel_a       = '0;
    sel_b       = '0;
    sel_csr     = '0;
    sel_ap      = '0;
    sel_csr_ren = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == ID_W'(i)) begin
        req_ready[i] = accept;
        sel_a        = req_a[32*i +: 32];
        sel_b        = req_b[32*i +: 32];
        sel_csr      = req_csr_rddata[32*i +: 32];
        sel_ap       = req_ap[AP_W*i +: AP_W];
        sel_csr_ren  = req_csr_ren[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Issue stage: bundle and strobes are zero on idle cycles, operands hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      bmu_valid_in      <= 1'b0;
      bmu_ap            <= '0;
      bmu_csr_ren_in    <= 1'b0;
      bmu_a_in          <= '0;
      bmu_b_in          <= '0;
      bmu_csr_rddata_in <= '0;
    end else begin
      bmu_valid_in   <= accept;
      bmu_ap         <= accept ? sel_ap : '0;
      bmu_csr_ren_in <= accept & sel_csr_ren;
      if (accept) begin
        bmu_a_in          <= sel_a;
        bmu_b_in          <= sel_b;
        bmu_csr_rddata_in <= sel_csr;
      end
    end
  end

  // Tag pipe: stage k is valid in the (k+1)th cycle after accept; the last stage lines up with bmu_result_ff.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= accept;
      for (int k = 1; k <= LAT; k++) tag_vld[k] <= tag_vld[k-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= winner;
    for (int k = 1; k <= LAT; k++) tag_id[k] <= tag_id[k-1];
  end

  // Response stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (tag_out) begin
        rsp_valid[tag_id[LAT]] <= 1'b1;
        rsp_result             <= bmu_result_ff;
        rsp_error              <= bmu_error;
      end
    end
  end

  // Retiring at tag exit lets flush_done rise the cycle after the final rsp_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({accept, tag_out})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_bmu_issue_arbiter.sv
// Directed bench for bmu_issue_arbiter with a one-cycle BMU stand-in and a
// response scoreboard fed by the stimulus sequence.
module tb_bmu_issue_arbiter;

  localparam int NREQ = 2;
  localparam int AP_W = 23;
  localparam int LAT  = 1;
  localparam logic [AP_W-1:0] AP_ADD  = 23'h000200;
  localparam logic [AP_W-1:0] AP_LAND = 23'h010000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*32-1:0]    req_a, req_b, req_csr_rddata;
  logic [NREQ*AP_W-1:0]  req_ap;
  logic [NREQ-1:0]       req_csr_ren;
  logic [NREQ-1:0]       rsp_valid;
  logic [31:0]           rsp_result;
  logic                  rsp_error;
  logic                  flush, flush_done, scan_mode;
  logic                  bmu_rst_l, bmu_valid_in, bmu_csr_ren_in, bmu_scan_mode;
  logic [31:0]           bmu_a_in, bmu_b_in, bmu_csr_rddata_in;
  logic [AP_W-1:0]       bmu_ap;
  logic [31:0]           bmu_result_ff;
  logic                  bmu_error;

  typedef struct packed {
    logic [NREQ-1:0] v;
    logic [31:0]     r;
    logic            e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bmu_issue_arbiter #(.NREQ(NREQ), .AP_W(AP_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ap(req_ap),
    .req_csr_ren(req_csr_ren), .req_csr_rddata(req_csr_rddata),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .flush(flush), .flush_done(flush_done), .scan_mode(scan_mode),
    .bmu_rst_l(bmu_rst_l), .bmu_valid_in(bmu_valid_in), .bmu_csr_ren_in(bmu_csr_ren_in),
    .bmu_a_in(bmu_a_in), .bmu_b_in(bmu_b_in), .bmu_csr_rddata_in(bmu_csr_rddata_in),
    .bmu_ap(bmu_ap), .bmu_scan_mode(bmu_scan_mode),
    .bmu_result_ff(bmu_result_ff), .bmu_error(bmu_error)
  );

  // BMU stand-in with one cycle of latency: csr read, add with signed overflow, and.
  always @(posedge clk) begin
    logic [31:0] s;
    s = bmu_a_in + bmu_b_in;
    if (bmu_csr_ren_in) begin
      bmu_result_ff <= bmu_csr_rddata_in;
      bmu_error     <= 1'b0;
    end else if (bmu_ap[9]) begin
      bmu_result_ff <= s;
      bmu_error     <= (bmu_a_in[31] == bmu_b_in[31]) && (s[31] != bmu_a_in[31]);
    end else if (bmu_ap[16]) begin
      bmu_result_ff <= bmu_a_in & bmu_b_in;
      bmu_error     <= 1'b0;
    end else begin
      bmu_result_ff <= '0;
      bmu_error     <= 1'b0;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      exp_t x;
      checks++;
      if (sb.size() == 0) begin
        assert (rsp_valid === '0) else begin
          errors++;
          $error("FAIL rsp_unexpected obs=%b exp=00", rsp_valid);
        end
      end else begin
        x = sb.pop_front();
        assert ((rsp_valid === x.v) && (rsp_result === x.r) && (rsp_error === x.e)) else begin
          errors++;
          $error("FAIL rsp obs=%b/%h/%b exp=%b/%h/%b", rsp_valid, rsp_result, rsp_error, x.v, x.r, x.e);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clr_req();
    req_valid      = '0;
    req_a          = '0;
    req_b          = '0;
    req_ap         = '0;
    req_csr_ren    = '0;
    req_csr_rddata = '0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [AP_W-1:0] ap);
    req_valid[i]          = 1'b1;
    req_a[32*i +: 32]     = a;
    req_b[32*i +: 32]     = b;
    req_ap[AP_W*i +: AP_W] = ap;
  endtask

  task automatic push(input logic [NREQ-1:0] v, input logic [31:0] r, input logic e);
    exp_t x;
    x.v = v;
    x.r = r;
    x.e = e;
    sb.push_back(x);
  endtask

  initial begin
    logic [31:0] a0, b0, a1, b1;
    rst = 1'b1;
    flush = 1'b0;
    scan_mode = 1'b0;
    clr_req();
    req_valid = 2'b11;
    step();
    step();
    sample();
    check("rst_bmu_rst_l", 32'(bmu_rst_l), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_bmu_valid", 32'(bmu_valid_in), 32'd0);
    check("rst_bmu_ap", 32'(bmu_ap), 32'd0);
    check("rst_bmu_a", bmu_a_in, 32'd0);
    check("rst_bmu_csr", bmu_csr_rddata_in, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);

    step();
    rst = 1'b0;
    clr_req();
    step();

    // single add on req0
    set_req(0, 32'd5, 32'd7, AP_ADD);
    push(2'b01, 32'd12, 1'b0);
    sample();
    check("add_ready", 32'(req_ready), 32'b01);
    check("bmu_rst_l_run", 32'(bmu_rst_l), 32'd1);
    step();
    clr_req();
    sample();
    check("add_bmu_valid", 32'(bmu_valid_in), 32'd1);
    check("add_bmu_a", bmu_a_in, 32'd5);
    check("add_bmu_b", bmu_b_in, 32'd7);
    check("add_bmu_ap", 32'(bmu_ap), 32'(AP_ADD));
    step();
    sample();
    check("add_idle_valid", 32'(bmu_valid_in), 32'd0);
    check("add_idle_ap", 32'(bmu_ap), 32'd0);
    check("add_hold_a", bmu_a_in, 32'd5);
    step();
    sample();
    check("add_rsp_timing", 32'(rsp_valid), 32'b01);
    step();
    step();

    // overflow on req1 leaves rr_ptr at 0
    set_req(1, 32'h7FFFFFFF, 32'd1, AP_ADD);
    push(2'b10, 32'h80000000, 1'b1);
    sample();
    check("ovf_ready", 32'(req_ready), 32'b10);
    step();
    clr_req();
    step();
    step();
    sample();
    check("ovf_rsp_timing", 32'(rsp_valid), 32'b10);
    step();
    step();

    // contention: both valid for four cycles
    for (int k = 0; k < 4; k++) begin
      a0 = 32'hF0F0_0000 | 32'(k);
      b0 = 32'h0FF0_FF0F;
      a1 = 32'h1234_5670 + 32'(k);
      b1 = 32'hFFFF_000F;
      set_req(0, a0, b0, AP_LAND);
      set_req(1, a1, b1, AP_LAND);
      if ((k % 2) == 0) push(2'b01, a0 & b0, 1'b0);
      else              push(2'b10, a1 & b1, 1'b0);
      sample();
      check("rr_ready", 32'(req_ready), ((k % 2) == 0) ? 32'b01 : 32'b10);
      step();
    end
    clr_req();
    for (int k = 0; k < 4; k++) step();

    // flush with two in flight
    set_req(0, 32'd1, 32'd2, AP_ADD);
    push(2'b01, 32'd3, 1'b0);
    sample();
    check("fl_ready_n0", 32'(req_ready), 32'b01);
    step();
    set_req(0, 32'd3, 32'd4, AP_ADD);
    push(2'b01, 32'd7, 1'b0);
    step();
    set_req(1, 32'd9, 32'd9, AP_ADD);
    flush = 1'b1;
    sample();
    check("fl_ready_gated", 32'(req_ready), 32'b00);
    step();
    sample();
    check("fl_done_n3", 32'(flush_done), 32'd0);
    check("fl_ready_n3", 32'(req_ready), 32'b00);
    step();
    sample();
    check("fl_done_n4", 32'(flush_done), 32'd0);
    step();
    sample();
    check("fl_done_n5", 32'(flush_done), 32'd1);
    step();
    sample();
    check("fl_done_n6", 32'(flush_done), 32'd1);
    check("fl_ready_halt", 32'(req_ready), 32'b00);
    step();
    clr_req();
    flush = 1'b0;
    step();
    set_req(1, 32'd10, 32'd20, AP_ADD);
    push(2'b10, 32'd30, 1'b0);
    sample();
    check("fl_resume_ready", 32'(req_ready), 32'b10);
    check("fl_resume_done", 32'(flush_done), 32'd0);
    step();
    clr_req();
    for (int k = 0; k < 4; k++) step();

    // flush with nothing in flight
    flush = 1'b1;
    step();
    sample();
    check("fl0_done_f1", 32'(flush_done), 32'd0);
    step();
    sample();
    check("fl0_done_f2", 32'(flush_done), 32'd1);
    flush = 1'b0;
    step();
    step();

    // reset while an operation is in flight
    set_req(0, 32'd100, 32'd1, AP_ADD);
    sample();
    check("rm_ready", 32'(req_ready), 32'b01);
    step();
    clr_req();
    rst = 1'b1;
    sample();
    check("rm_bmu_valid", 32'(bmu_valid_in), 32'd1);
    check("rm_bmu_rst_l", 32'(bmu_rst_l), 32'd0);
    step();
    rst = 1'b0;
    sample();
    check("rm_post_valid", 32'(bmu_valid_in), 32'd0);
    check("rm_post_a", bmu_a_in, 32'd0);
    check("rm_post_rsp", 32'(rsp_valid), 32'd0);
    step();
    set_req(0, 32'd200, 32'd3, AP_ADD);
    set_req(1, 32'd50, 32'd50, AP_ADD);
    push(2'b01, 32'd203, 1'b0);
    sample();
    check("rm_ptr_zero", 32'(req_ready), 32'b01);
    step();
    clr_req();
    set_req(1, 32'd7, 32'd8, AP_ADD);
    push(2'b10, 32'd15, 1'b0);
    sample();
    check("rm_req1_ready", 32'(req_ready), 32'b10);
    check("rm_no_stale_rsp", 32'(rsp_valid), 32'd0);
    step();
    clr_req();
    for (int k = 0; k < 4; k++) step();

    // idle hygiene, then a csr op with a multi-hot bundle
    for (int k = 0; k < 5; k++) begin
      sample();
      check("idle_valid", 32'(bmu_valid_in), 32'd0);
      check("idle_ap", 32'(bmu_ap), 32'd0);
      step();
    end
    set_req(0, 32'd1, 32'd2, 23'h410201);
    req_csr_ren[0] = 1'b1;
    req_csr_rddata[31:0] = 32'hDEADBEEF;
    push(2'b01, 32'hDEADBEEF, 1'b0);
    sample();
    check("csr_ready", 32'(req_ready), 32'b01);
    step();
    clr_req();
    sample();
    check("csr_ren_fwd", 32'(bmu_csr_ren_in), 32'd1);
    check("csr_data_fwd", bmu_csr_rddata_in, 32'hDEADBEEF);
    check("csr_ap_pass", 32'(bmu_ap), 32'h410201);
    step();
    sample();
    check("csr_ren_idle", 32'(bmu_csr_ren_in), 32'd0);
    check("csr_data_hold", bmu_csr_rddata_in, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) step();

    sample();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bmu_issue_arbiter.md
# bmu_issue_arbiter

Round-robin issue controller that shares one BMU (bit-manipulation unit) between NREQ requesters. It drives the BMU operand, opcode-bundle and CSR inputs, and tracks each accepted operation through the BMU's fixed result latency. Each result/error pair is returned to the requester that issued it. It also provides a flush/quiesce handshake so the pipeline can drain the BMU before scan or mode changes.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..4)
- AP_W, 23, width of the BMU opcode bundle `ap` (bit 22 = csr_write … bit 9 = add … bit 0 = gorc)
- LAT, 1, BMU latency from `valid_in` cycle to `result_ff` cycle

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester operation valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ*32  operand 1, requester i at [32i+31:32i]
- req_b  in  NREQ*32  operand 2
- req_ap  in  NREQ*AP_W  opcode bundle
- req_csr_ren  in  NREQ  CSR read enable
- req_csr_rddata  in  NREQ*32  CSR read data
- rsp_valid  out  NREQ  one-hot response strobe, no backpressure
- rsp_result  out  32  BMU result
- rsp_error  out  1  BMU error flag
- flush  in  1  request quiesce
- flush_done  out  1  BMU empty and issue halted
- scan_mode  in  1  passed to BMU
- bmu_rst_l  out  1  = ~rst
- bmu_valid_in, bmu_csr_ren_in  out  1  registered
- bmu_a_in, bmu_b_in, bmu_csr_rddata_in  out  32  registered
- bmu_ap  out  AP_W  registered
- bmu_scan_mode  out  1  = scan_mode
- bmu_result_ff  in  32  BMU result
- bmu_error  in  1  BMU error

## Operation
- State machine with three states: RUN, DRAIN, HALTED. Reset state is RUN.
  - RUN → DRAIN when flush=1.
  - DRAIN → HALTED when inflight=0 and flush=1.
  - DRAIN → RUN when inflight=0 and flush=0.
  - HALTED → RUN when flush=0.
- Grant is only possible in RUN with flush=0. The winner is the first valid requester at or after `rr_ptr`, searching upward with wrap. `req_ready` is combinational and one-hot on the winner. A request is accepted when valid&ready.
- On accept, `rr_ptr` becomes winner+1 mod NREQ. It is unchanged on cycles with no grant. Reset value is 0.
- Accepted fields are registered into the bmu_* outputs. On cycles with no accept: bmu_valid_in=0, bmu_ap=0, bmu_csr_ren_in=0; a/b/csr_rddata hold their last values.
- A tag pipe of depth LAT+1 carries {valid, requester id}. When the tag reaches the output, bmu_result_ff and bmu_error are registered into rsp_result and rsp_error, and rsp_valid[id] is set for one cycle.
- `inflight` counter, width clog2(LAT+3): +1 on accept, −1 on rsp_valid. Both events in the same cycle leave it unchanged. Never exceeds LAT+2.
- The opcode bundle is not decoded or checked; illegal multi-hot bundles pass through unchanged.
- flush_done=1 exactly while in HALTED.

## Timing
- Accept in cycle N. bmu_valid_in=1 in N+1. bmu_result_ff is sampled in N+1+LAT. rsp_valid is asserted in N+2+LAT (N+3 for LAT=1).
- Throughput is one operation per cycle. Responses return in issue order.
- flush raised in cycle F: req_ready=0 from cycle F. In-flight operations complete normally. flush_done rises the cycle after the last rsp_valid. If nothing is in flight, flush_done rises in F+2.
- Reset values of all registered outputs are 0: rsp_*, flush_done, bmu_valid_in, bmu_ap, bmu_a_in, bmu_b_in, bmu_csr_*. bmu_rst_l=0 during reset.
- Reset mid-operation: tag pipe and inflight cleared, pending results dropped (no rsp_valid), rr_ptr=0. The first accept is possible in the first cycle with rst=0.
- A simultaneous accept and flush assertion cannot occur, because flush gates ready in the same cycle.

## Test plan
- Single add: req0 a=5, b=7, ap=23'h000200 accepted at N → bmu_valid_in at N+1; rsp_valid=2'b01 at N+3, rsp_result=12, rsp_error=0.
- Contention: req0 and req1 both valid for 4 cycles with distinct land ops (ap=23'h010000) → grants 0,1,0,1; rsp_valid 01,10,01,10 on consecutive cycles with matching results.
- Overflow passthrough: req1 add a=32'h7FFFFFFF, b=1 → rsp_valid=2'b10, rsp_result=32'h80000000, rsp_error=1 three cycles later.
- Flush with 2 in flight: accepts at N and N+1, flush=1 at N+2 → req_ready=0 from N+2; responses at N+3 and N+4; flush_done=1 at N+5; flush=0 → RUN, and the next request is accepted in the same cycle it is presented.
- Reset mid-flight: accept at N, rst=1 at N+1 for one cycle → no rsp_valid ever for that op; all outputs 0 during reset; a subsequent req1-only request is granted; rr_ptr was reset to 0.
- Idle/bundle hygiene: no valid requests for 5 cycles → bmu_valid_in=0, bmu_ap=0; csr op (req_csr_ren=1, csr_rddata=32'hDEADBEEF) is forwarded to bmu_csr_* in the cycle after accept.
